// File: rtl/aes_decr_iter.sv
// aes_decr_iter: iterative AES-128/192/256 decryptor with
// on-chip key expansion and ECB/CBC chaining.
module aes_decr_iter #(
  parameter int KEY_BITS = 128,
  parameter int UNROLL   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [127:0]        iv_in,
  input  logic                iv_load,
  input  logic                cbc_en,
  input  logic [127:0]        in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [127:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] KEYEXP = 3'd1;
  localparam logic [2:0] READY  = 3'd2;
  localparam logic [2:0] ROUND  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    return ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey (+ InvMixColumns)
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic last);
    logic [127:0] t, m;
    logic [7:0] a0, a1, a2, a3;
    t = '0;
    m = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] =
          isbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
    t = t ^ k;
    for (int c = 0; c < 4; c++) begin
      a0 = t[127-32*c -: 8];
      a1 = t[119-32*c -: 8];
      a2 = t[111-32*c -: 8];
      a3 = t[103-32*c -: 8];
      m[127-32*c -: 32] = {
        gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
        gmul(a0, 8'd9) ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
        gmul(a0, 8'd13) ^ gmul(a1, 8'd9) ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
        gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9) ^ gmul(a3, 8'd14)};
    end
    return last ? t : m;
  endfunction

  logic [2:0]   r_st;
  logic [31:0]  r_w [NW];
  logic [5:0]   r_ki;
  logic [2:0]   r_kj;
  logic [7:0]   r_rcon;
  logic [127:0] r_s, r_ct, r_chain, r_out;
  logic [3:0]   r_rnd;
  logic         r_cbc;

  logic [31:0]  w_prev, w_temp;
  logic [3:0]   w_rnd2;
  logic [127:0] w_knr, w_k1, w_k2, w_r1, w_r2, w_nxt;
  logic         w_last;

  // next schedule word transform (RotWord/SubWord/Rcon)
  always_comb begin
    w_prev = r_w[r_ki - 6'd1];
    w_temp = w_prev;
    if (r_kj == 3'd0)
      w_temp = subw({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    else if (NK > 6 && r_kj == 3'd4)
      w_temp = subw(w_prev);
  end

  // round key fetch and the UNROLL inverse rounds of this cycle
  always_comb begin
    w_rnd2 = (r_rnd == 4'd0) ? 4'd0 : r_rnd - 4'd1;
    w_knr  = {r_w[6'(4*NR)], r_w[6'(4*NR+1)],
              r_w[6'(4*NR+2)], r_w[6'(4*NR+3)]};
    w_k1   = {r_w[{r_rnd, 2'd0}], r_w[{r_rnd, 2'd1}],
              r_w[{r_rnd, 2'd2}], r_w[{r_rnd, 2'd3}]};
    w_k2   = {r_w[{w_rnd2, 2'd0}], r_w[{w_rnd2, 2'd1}],
              r_w[{w_rnd2, 2'd2}], r_w[{w_rnd2, 2'd3}]};
    w_r1   = inv_round(r_s, w_k1, r_rnd == 4'd0);
    w_r2   = inv_round(w_r1, w_k2, r_rnd == 4'd1);
    w_nxt  = (UNROLL == 2) ? w_r2 : w_r1;
    w_last = (UNROLL == 2) ? (r_rnd == 4'd1) : (r_rnd == 4'd0);
  end

  // control FSM, key schedule, datapath and chaining state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= IDLE;
      r_ki    <= 6'(NK);
      r_kj    <= '0;
      r_rcon  <= 8'h01;
      r_s     <= '0;
      r_ct    <= '0;
      r_chain <= '0;
      r_out   <= '0;
      r_rnd   <= '0;
      r_cbc   <= 1'b0;
    end else begin
      unique case (r_st)
        IDLE, READY: begin
          if (iv_load) r_chain <= iv_in;
          if (key_valid) begin
            for (int i = 0; i < NK; i++)
              r_w[i] <= key_in[KEY_BITS-1-32*i -: 32];
            r_ki   <= 6'(NK);
            r_kj   <= '0;
            r_rcon <= 8'h01;
            r_st   <= KEYEXP;
          end else if (r_st == READY && in_valid) begin
            r_s   <= in_data ^ w_knr;
            r_ct  <= in_data;
            r_cbc <= cbc_en;
            r_rnd <= 4'(NR - 1);
            r_st  <= ROUND;
          end
        end
        KEYEXP: begin
          r_w[r_ki] <= r_w[r_ki - 6'(NK)] ^ w_temp;
          r_kj <= (r_kj == 3'(NK - 1)) ? 3'd0 : r_kj + 3'd1;
          if (r_kj == 3'd0) r_rcon <= xt(r_rcon);
          if (r_ki == 6'(NW - 1)) r_st <= READY;
          else r_ki <= r_ki + 6'd1;
        end
        ROUND: begin
          r_s <= w_nxt;
          if (w_last) begin
            r_out <= w_nxt ^ (r_cbc ? r_chain : 128'h0);
            if (r_cbc) r_chain <= r_ct;
            r_st <= DONE;
          end else begin
            r_rnd <= r_rnd - 4'(UNROLL);
          end
        end
        DONE: if (out_ready) r_st <= READY;
        default: r_st <= IDLE;
      endcase
    end
  end

  assign key_ready = !rst && (r_st == IDLE || r_st == READY);
  assign in_ready  = !rst && r_st == READY && !key_valid;
  assign out_valid = (r_st == DONE);
  assign out_data  = r_out;
  assign busy      = (r_st == KEYEXP || r_st == ROUND);

endmodule

// File: tb/tb_aes_decr_iter.sv
// tb_aes_decr_iter: directed FIPS-197 / SP800-38A vectors,
// handshake, hold and abort checks.
module tb_aes_decr_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, key_valid, iv_load, cbc_en, in_valid, out_ready;
  logic [127:0] key_in, iv_in, in_data;
  logic         key_ready, in_ready, out_valid, busy;
  logic [127:0] out_data;

  aes_decr_iter #(.KEY_BITS(128), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .iv_in(iv_in), .iv_load(iv_load),
    .cbc_en(cbc_en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy));

  // auxiliary instances for the other key sizes / unroll factors
  logic [255:0] key256;
  logic         a_kv, a_iv;
  logic [127:0] a_in [4];
  logic         a_kr [4];
  logic         a_ir [4];
  logic         a_ov [4];
  logic         a_bz [4];
  logic [127:0] a_od [4];

  aes_decr_iter #(.KEY_BITS(192), .UNROLL(1)) a0 (
    .clk(clk), .rst(rst), .key_in(key256[255:64]), .key_valid(a_kv),
    .key_ready(a_kr[0]), .iv_in(128'h0), .iv_load(1'b0), .cbc_en(1'b0),
    .in_data(a_in[0]), .in_valid(a_iv), .in_ready(a_ir[0]),
    .out_data(a_od[0]), .out_valid(a_ov[0]), .out_ready(1'b1),
    .busy(a_bz[0]));
  aes_decr_iter #(.KEY_BITS(256), .UNROLL(1)) a1 (
    .clk(clk), .rst(rst), .key_in(key256), .key_valid(a_kv),
    .key_ready(a_kr[1]), .iv_in(128'h0), .iv_load(1'b0), .cbc_en(1'b0),
    .in_data(a_in[1]), .in_valid(a_iv), .in_ready(a_ir[1]),
    .out_data(a_od[1]), .out_valid(a_ov[1]), .out_ready(1'b1),
    .busy(a_bz[1]));
  aes_decr_iter #(.KEY_BITS(128), .UNROLL(2)) a2 (
    .clk(clk), .rst(rst), .key_in(key256[255:128]), .key_valid(a_kv),
    .key_ready(a_kr[2]), .iv_in(128'h0), .iv_load(1'b0), .cbc_en(1'b0),
    .in_data(a_in[2]), .in_valid(a_iv), .in_ready(a_ir[2]),
    .out_data(a_od[2]), .out_valid(a_ov[2]), .out_ready(1'b1),
    .busy(a_bz[2]));
  aes_decr_iter #(.KEY_BITS(256), .UNROLL(2)) a3 (
    .clk(clk), .rst(rst), .key_in(key256), .key_valid(a_kv),
    .key_ready(a_kr[3]), .iv_in(128'h0), .iv_load(1'b0), .cbc_en(1'b0),
    .in_data(a_in[3]), .in_valid(a_iv), .in_ready(a_ir[3]),
    .out_data(a_od[3]), .out_valid(a_ov[3]), .out_ready(1'b1),
    .busy(a_bz[3]));

  typedef struct {
    string        nm;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } avec_t;

  typedef struct {
    string        nm;
    logic         cbc;
    logic         ivld;
    logic [127:0] iv;
    logic [127:0] ct;
    logic [127:0] pt;
    logic         hold;
  } mvec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    int n;
    key_in    = k;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    chk("keyexp_busy", busy, 1'b1);
    chk("keyexp_key_ready", key_ready, 1'b0);
    n = 0;
    while (!in_ready && n < 200) begin
      tick;
      n++;
    end
    chk("keyexp_cycles", n, 40);
  endtask

  task automatic run_block(input mvec_t v);
    int  lat;
    logic ok;
    cbc_en    = v.cbc;
    iv_load   = v.ivld;
    iv_in     = v.iv;
    in_data   = v.ct;
    out_ready = !v.hold;
    chk({v.nm, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    iv_load  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick;
      lat++;
    end
    chk({v.nm, "_latency"}, lat, 10);
    chk({v.nm, "_pt"}, out_data, v.pt);
    if (v.hold) begin
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
        in_valid = 1'b1;
        iv_load  = 1'b1;
        iv_in    = 128'hdeadbeef_00000000_12345678_9abcdef0;
        in_data  = 128'hffff0000_ffff0000_ffff0000_ffff0000;
        tick;
        if (out_data !== v.pt || out_valid !== 1'b1 || in_ready !== 1'b0)
          ok = 1'b0;
      end
      chk({v.nm, "_hold_stable"}, ok, 1'b1);
      out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      iv_load  = 1'b0;
      chk({v.nm, "_release_no_accept"}, busy, 1'b0);
      chk({v.nm, "_release_ov"}, out_valid, 1'b0);
    end else begin
      tick;
    end
  endtask

  avec_t av [4];
  mvec_t mv [3];
  int    got [4];
  logic [127:0] gpt [4];
  logic  ok;
  int    n;

  initial begin
    av[0] = '{"k192_u1", 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
              128'h00112233445566778899aabbccddeeff, 12};
    av[1] = '{"k256_u1", 128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 14};
    av[2] = '{"k128_u2", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 5};
    av[3] = '{"k256_u2", 128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 7};
    mv[0] = '{"cbc1", 1'b1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
              128'h7649abac8119b246cee98e9b12e9197d,
              128'h6bc1bee22e409f96e93d7e117393172a, 1'b0};
    mv[1] = '{"ecb_hold", 1'b0, 1'b0, 128'h0,
              128'h3ad77bb40d7a3660a89ecaf32466ef97,
              128'h6bc1bee22e409f96e93d7e117393172a, 1'b1};
    mv[2] = '{"cbc2", 1'b1, 1'b0, 128'h0,
              128'h5086cb9b507219ee95db113a917678b2,
              128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0};

    key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    rst = 1'b1;
    key_valid = 1'b0; iv_load = 1'b0; cbc_en = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; key_in = '0; iv_in = '0; in_data = '0;
    a_kv = 1'b0; a_iv = 1'b0;
    for (int i = 0; i < 4; i++) a_in[i] = av[i].ct;
    tick;
    tick;
    chk("rst_key_ready", key_ready, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_key_ready", key_ready, 1'b1);
    chk("idle_in_ready", in_ready, 1'b0);

    a_kv = 1'b1;
    tick;
    a_kv = 1'b0;
    n = 0;
    while (!(a_ir[0] && a_ir[1] && a_ir[2] && a_ir[3]) && n < 200) begin
      tick;
      n++;
    end
    chk("aux_keyexp_done", (n < 200), 1'b1);
    a_iv = 1'b1;
    tick;
    a_iv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got[i] = -1;
      gpt[i] = '0;
    end
    for (int c = 1; c <= 30; c++) begin
      tick;
      for (int i = 0; i < 4; i++)
        if (a_ov[i] && got[i] < 0) begin
          got[i] = c;
          gpt[i] = a_od[i];
        end
    end
    for (int i = 0; i < 4; i++) begin
      chk({av[i].nm, "_latency"}, got[i], av[i].lat);
      chk({av[i].nm, "_pt"}, gpt[i], av[i].pt);
    end

    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int i = 0; i < 3; i++) run_block(mv[i]);

    key_in    = 128'h000102030405060708090a0b0c0d0e0f;
    key_valid = 1'b1;
    in_data   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    in_valid  = 1'b1;
    #1;
    chk("collide_in_ready", in_ready, 1'b0);
    chk("collide_key_ready", key_ready, 1'b1);
    tick;
    key_valid = 1'b0;
    in_valid  = 1'b0;
    chk("collide_keyexp", busy, 1'b1);
    n = 0;
    while (!in_ready && n < 200) begin
      tick;
      n++;
    end
    chk("collide_keyexp_cycles", n, 40);
    run_block('{"ecb128", 1'b0, 1'b0, 128'h0,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 1'b0});
    run_block('{"cbc_retained", 1'b1, 1'b0, 128'h0,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h5097e9a814277f991d42bb815dab964d, 1'b0});

    cbc_en   = 1'b0;
    in_data  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    chk("abort_in_round", busy, 1'b1);
    rst = 1'b1;
    tick;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_data", out_data, 128'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_key_ready", key_ready, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (15) begin
      tick;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0)
        ok = 1'b0;
    end
    chk("abort_quiet", ok, 1'b1);
    chk("abort_idle_key_ready", key_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/aes_decr_iter.md
AES_DECR_ITER -- requirements
Module: aes_decr_iter

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, meaning the AES key size; legal values are 128, 192 and 256, giving Nr = 10, 12 and 14.
REQ-002 SHALL have parameter UNROLL, default 1, meaning inverse rounds computed per clock; legal values are 1 and 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port key_in, input, KEY_BITS bits, the cipher key; bit KEY_BITS-1 is the MSB of key byte 0 (FIPS-197 order).
REQ-006 SHALL have ports key_valid (input, 1 bit) and key_ready (output, 1 bit), the key-load handshake.
REQ-007 SHALL have ports iv_in (input, 128 bits) and iv_load (input, 1 bit), which load the CBC chaining value.
REQ-008 SHALL have port cbc_en, input, 1 bit; 1 selects CBC decrypt and 0 selects ECB decrypt; sampled at ciphertext acceptance.
REQ-009 SHALL have ports in_data (input, 128 bits; bit 127 = byte 0), in_valid (input, 1 bit) and in_ready (output, 1 bit), the ciphertext handshake.
REQ-010 SHALL have ports out_data (output, 128 bits), out_valid (output, 1 bit) and out_ready (input, 1 bit), the plaintext handshake.
REQ-011 SHALL have port busy, output, 1 bit, high in states KEYEXP and ROUND.

Function
REQ-012 SHALL implement FSM states IDLE, KEYEXP, READY, ROUND and DONE.
REQ-013 IDLE SHALL mean no valid key schedule; key_ready=1 and in_ready=0.
REQ-014 key_valid&&key_ready SHALL capture key_in into schedule words 0..Nk-1 (Nk = KEY_BITS/32) and go to KEYEXP; this is legal in IDLE and READY only.
REQ-015 KEYEXP SHALL compute one schedule word per cycle, words Nk..4*Nr+3 (40/46/52 cycles), using RotWord/SubWord/Rcon and the extra SubWord for Nk=8 at i mod 8 = 4; it SHALL then go to READY.
REQ-016 READY SHALL drive in_ready=1 and key_ready=1; key_ready=0 in all other states except IDLE.
REQ-017 If key_valid and in_valid are both high in READY, the key load SHALL win and in_ready SHALL be 0 that cycle (in_ready = state==READY && !key_valid).
REQ-018 in_valid&&in_ready SHALL load state = in_data XOR K[Nr], latch cbc_en and in_data, and go to ROUND.
REQ-019 ROUND SHALL apply UNROLL inverse rounds per cycle, using round keys in descending order: Nr-1 full rounds (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), then a final round without InvMixColumns using K[0].
REQ-020 ROUND SHALL last exactly Nr/UNROLL cycles; out_valid SHALL rise Nr/UNROLL clock edges after the acceptance edge (10 for KEY_BITS=128, UNROLL=1).
REQ-021 DONE: out_data = plaintext when ECB; out_data = plaintext XOR chain when CBC, after which chain := latched ciphertext.
REQ-022 DONE: out_data and out_valid SHALL remain stable until out_ready; on out_valid&&out_ready the FSM SHALL return to READY, with no new input accepted in that same cycle.
REQ-023 In ECB mode the chain register SHALL not be modified.
REQ-024 iv_load SHALL write chain := iv_in only in IDLE or READY; it SHALL be ignored otherwise.
REQ-025 iv_load coinciding with acceptance SHALL take effect before that block uses chain.
REQ-026 key_valid, in_valid and iv_load SHALL be ignored in KEYEXP, ROUND and DONE; no input is stored for later use.
REQ-027 A new key load SHALL invalidate the previous schedule; chain SHALL be retained.
REQ-028 The round counter SHALL be 4 bits and SHALL never wrap; the schedule store SHALL hold 4*(Nr+1) 32-bit words.

Reset
REQ-029 rst SHALL set: state=IDLE, key_ready=0 during reset then 1, in_ready=0, out_valid=0, out_data=0, busy=0, chain=0, schedule invalid.
REQ-030 rst in KEYEXP, ROUND or DONE SHALL abort the operation; no out_valid SHALL follow, and a fresh key load SHALL be required.

Verification
REQ-031 KEY_BITS=128: key 000102030405060708090a0b0c0d0e0f; ECB ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, out_valid 10 edges after acceptance.
REQ-032 KEY_BITS=192: key 000102..17; ct dda97ca4864cdfe06eaf70a0ec0d7191 -> same pt. KEY_BITS=256: key 000102..1f; ct 8ea2b7ca516745bfeafc49904b496089 -> same pt. Repeat with UNROLL=2 and check halved latency.
REQ-033 CBC, KEY_BITS=128: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102..0f; ct 7649abac8119b246cee98e9b12e9197d -> 6bc1bee22e409f96e93d7e117393172a; then ct 5086cb9b507219ee95db113a917678b2 -> ae2d8a571e03ac9c9eb76fac45af8e51.
REQ-034 Hold out_ready=0 for 20 cycles in DONE -> out_data and out_valid stable; in_ready=0; in_valid and iv_load ignored.
REQ-035 Assert rst at ROUND cycle 5 -> all outputs 0, IDLE, no out_valid; assert key_valid and in_valid together in READY -> key accepted, block not accepted.
